mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one unified memory/MIO bus between two requesters: the instruction-fetch port (read only) and the MEM-stage data port (read/write with DMType).
- Sits between the pipelined CPU core and the memory/MIO subsystem.
- Drives per-port stall signals back to the pipeline while a port waits.
- Handles variable-latency memory through a ready handshake, with a timeout guard.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_STREAK, 4, max consecutive data grants while a fetch is pending before fetch is forced
TIMEOUT, 255, cycles in BUSY before abort; 0 disables timeout
TW, 8, width of timeout and streak counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
if_req  in  1  fetch request, held until if_done
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched instruction, valid when if_done
if_done  out  1  one-cycle completion pulse
dm_req  in  1  data request, held until dm_done
dm_we  in  1  1 = store
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_type  in  3  DMType encoding, passed through unchanged
dm_rdata  out  DW  load data, valid when dm_done
dm_done  out  1  one-cycle completion pulse
bus_req  out  1  memory request
bus_we  out  1  memory write enable
bus_addr  out  AW  memory address
bus_wdata  out  DW  memory write data
bus_dmtype  out  3  DMType to memory
bus_rdata  in  DW  memory read data
bus_ready  in  1  memory completion (MIO_ready semantics)
stall_if  out  1  if_req & ~if_done
stall_mem  out  1  dm_req & ~dm_done
bus_err  out  1  sticky timeout flag, cleared only by rst

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (asynchronous, any state):
  - state = IDLE.
  - All registered outputs = 0: bus_req, bus_we, bus_addr, bus_wdata, bus_dmtype, if_rdata, dm_rdata, if_done, dm_done, bus_err.
  - Streak and timeout counters = 0.
  - Reset mid-transaction abandons the transaction; no done pulse is issued.
- IDLE:
  - If neither request is active, stay.
  - If exactly one is active, grant it.
  - If both are active, grant data unless streak == MAX_STREAK, in which case grant fetch.
  - On grant: latch addr, wdata, we, dmtype and owner into registers; go to BUSY.
  - bus_req goes high the cycle after the grant edge.
  - Fetch grants force bus_we = 0 and bus_dmtype = 3'b010 (word).
- BUSY:
  - bus_req = 1 and the latched bus fields are held stable.
  - The timeout counter increments each cycle.
  - If bus_ready = 1: capture bus_rdata into the owner's rdata register and go to RESP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: owner rdata = 0, bus_err = 1, go to RESP.
  - bus_ready and timeout in the same cycle: bus_ready wins and bus_err is not set.
- RESP:
  - Owner's done = 1 for exactly this cycle; bus_req = 0; the timeout counter clears.
  - Next state is IDLE.
  - The owner's req is ignored in this cycle. Requesters drop req, or present a new request, by the following cycle.
- Latency: request seen at edge N, bus_ready high during cycle N+k (k ≥ 1) → done high in cycle N+k+1. Minimum 3 cycles request-to-done with zero-wait memory.
- Streak counter:
  - Increments on a data grant made while if_req = 1.
  - Clears on any fetch grant, or on a data grant made while if_req = 0.
  - Saturates at MAX_STREAK.
- Owner req dropping during BUSY violates protocol; the transaction still completes normally.
- rdata registers hold their value until the owner's next completion.
- bus_we is 0 on loads. bus_wdata is don't-care on loads but still latched.
- stall_if and stall_mem are combinational from req and done.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x0000_0010, bus_ready asserted 2 cycles after bus_req, bus_rdata = 0x0000_0513 → bus_req high for 2 cycles with bus_we = 0; if_done pulses one cycle; if_rdata = 0x0000_0513; stall_if high until that cycle.
- Contention: if_req and dm_req rise on the same edge, store of 0xDEAD_BEEF to 0x100, dm_type = 3'b010 → data is served first with bus_we = 1, bus_addr = 0x100, bus_wdata = 0xDEAD_BEEF; fetch is served only after dm_done and RESP; no overlap of bus_req between the two.
- Starvation guard: if_req held high while 6 back-to-back data loads are issued, MAX_STREAK = 4 → grant order is D,D,D,D,F,D,D.
- Timeout: TIMEOUT = 8, dm_req load, bus_ready held 0 → dm_done exactly 9 cycles after the grant edge, dm_rdata = 0, bus_err = 1 and sticky; the next request completes normally.
- Simultaneous bus_ready and timeout: bus_ready = 1 on cycle TIMEOUT-1 with bus_rdata = 0x1234 → rdata = 0x1234, bus_err stays 0.
- Reset mid-BUSY: assert rst during a pending load → all outputs 0 immediately (asynchronous), no dm_done; after release, a fresh request completes with the 3-cycle minimum latency.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a shared memory/MIO bus. Instruction fetch and
// MEM-stage data accesses are serialised onto a single bus. Data has priority,
// but a streak counter forces a fetch grant after MAX_STREAK data grants made
// while a fetch was waiting. A timeout guard aborts bus cycles that never see
// bus_ready and raises a sticky error flag.
module mem_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255,
    parameter int TW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    // instruction-fetch port (read only)
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    // MEM-stage data port
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [2:0]    dm_type,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    // unified memory bus
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [2:0]    bus_dmtype,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ready,
    // pipeline stalls and status
    output logic          stall_if,
    output logic          stall_mem,
    output logic          bus_err
);

    localparam logic [2:0]    DMTYPE_WORD = 3'b010;
    localparam logic [TW-1:0] STREAK_MAX  = TW'(MAX_STREAK);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
    localparam bit            TMO_EN      = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_e;

    state_e          state_q,      state_d;
    owner_e          owner_q,      owner_d;
    logic            bus_req_q,    bus_req_d;
    logic            bus_we_q,     bus_we_d;
    logic [AW-1:0]   bus_addr_q,   bus_addr_d;
    logic [DW-1:0]   bus_wdata_q,  bus_wdata_d;
    logic [2:0]      bus_dmtype_q, bus_dmtype_d;
    logic [DW-1:0]   if_rdata_q,   if_rdata_d;
    logic [DW-1:0]   dm_rdata_q,   dm_rdata_d;
    logic            if_done_q,    if_done_d;
    logic            dm_done_q,    dm_done_d;
    logic            bus_err_q,    bus_err_d;
    logic [TW-1:0]   streak_q,     streak_d;
    logic [TW-1:0]   tmo_q,        tmo_d;
    logic            grant_fetch;

    // State and output registers; reset abandons any transaction in flight.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_DATA;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_dmtype_q <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_done_q    <= 1'b0;
            dm_done_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            streak_q     <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_dmtype_q <= bus_dmtype_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_done_q    <= if_done_d;
            dm_done_q    <= dm_done_d;
            bus_err_q    <= bus_err_d;
            streak_q     <= streak_d;
            tmo_q        <= tmo_d;
        end
    end

    // Next-state logic: arbitration in IDLE, wait/timeout in BUSY, done pulse in RESP.
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_dmtype_d = bus_dmtype_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_done_d    = 1'b0;
        dm_done_d    = 1'b0;
        bus_err_d    = bus_err_q;
        streak_d     = streak_q;
        tmo_d        = tmo_q;
        grant_fetch  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (if_req || dm_req) begin
                    // Data wins unless fetch has already waited out a full streak.
                    grant_fetch = if_req && (!dm_req || (streak_q == STREAK_MAX));
                    bus_req_d   = 1'b1;
                    state_d     = S_BUSY;
                    if (grant_fetch) begin
                        owner_d      = OWN_FETCH;
                        bus_we_d     = 1'b0;
                        bus_addr_d   = if_addr;
                        bus_wdata_d  = '0;
                        bus_dmtype_d = DMTYPE_WORD;
                        streak_d     = '0;
                    end else begin
                        owner_d      = OWN_DATA;
                        bus_we_d     = dm_we;
                        bus_addr_d   = dm_addr;
                        bus_wdata_d  = dm_wdata;
                        bus_dmtype_d = dm_type;
                        // Only grants that overtake a waiting fetch count toward the streak.
                        if (!if_req) begin
                            streak_d = '0;
                        end else if (streak_q < STREAK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end
                end
            end

            S_BUSY: begin
                tmo_d = tmo_q + 1'b1;
                // bus_ready is tested first so a late completion beats the timeout.
                if (bus_ready) begin
                    if (owner_q == OWN_FETCH) begin
                        if_rdata_d = bus_rdata;
                        if_done_d  = 1'b1;
                    end else begin
                        dm_rdata_d = bus_rdata;
                        dm_done_d  = 1'b1;
                    end
                    bus_req_d = 1'b0;
                    state_d   = S_RESP;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    if (owner_q == OWN_FETCH) begin
                        if_rdata_d = '0;
                        if_done_d  = 1'b1;
                    end else begin
                        dm_rdata_d = '0;
                        dm_done_d  = 1'b1;
                    end
                    bus_err_d = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = S_RESP;
                end
            end

            S_RESP: begin
                // The done pulse is visible this cycle; requests are not sampled here.
                tmo_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                bus_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_dmtype = bus_dmtype_q;
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign if_done    = if_done_q;
    assign dm_done    = dm_done_q;
    assign bus_err    = bus_err_q;

    assign stall_if   = if_req & ~if_done_q;
    assign stall_mem  = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requester tasks push expected
// grants and responses; a monitor pops and compares whenever the DUT starts a
// bus cycle or pulses a done.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_type;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [2:0]  bus_dmtype;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    mem_bus_arbiter #(
        .AW(32), .DW(32), .MAX_STREAK(4), .TIMEOUT(8), .TW(8)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_type(dm_type), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_dmtype(bus_dmtype), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  dmtype;
    } grant_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;   // cycles from first bus_req cycle to done cycle
    } resp_t;

    grant_t grant_q[$];
    resp_t  if_exp_q[$];
    resp_t  dm_exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_grant(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] dmtype);
        grant_t g;
        g.we = we; g.addr = addr; g.wdata = wdata; g.dmtype = dmtype;
        grant_q.push_back(g);
    endtask

    // ---------------- memory model ----------------
    // mem_wait = extra wait cycles after the first bus_req cycle; -1 = never ready.
    int          mem_wait  = 0;
    logic [31:0] mem_rdata = 32'h0;
    int          bcnt      = 0;

    initial begin
        bus_ready = 1'b0;
        bus_rdata = 32'hBADD_0000;
        forever begin
            @(negedge clk);
            if (bus_req && !rst) begin
                bcnt++;
                bus_ready = (mem_wait >= 0) && (bcnt == mem_wait + 1);
                bus_rdata = bus_ready ? mem_rdata : 32'hBADD_0000;
            end else begin
                bcnt      = 0;
                bus_ready = 1'b0;
                bus_rdata = 32'hBADD_0000;
            end
        end
    end

    // ---------------- monitor ----------------
    int     cyc = 0;
    int     rise_cyc = 0;
    logic   prev_req = 1'b0;
    grant_t cur_g;

    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                prev_req = 1'b0;
                continue;
            end
            if (bus_req && !prev_req) begin
                rise_cyc = cyc;
                if (grant_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant: addr 0x%08h with no grant expected", bus_addr);
                end else begin
                    cur_g = grant_q.pop_front();
                    check("grant_we", {31'b0, bus_we}, {31'b0, cur_g.we});
                    check("grant_addr", bus_addr, cur_g.addr);
                    check("grant_dmtype", {29'b0, bus_dmtype}, {29'b0, cur_g.dmtype});
                    if (cur_g.we) check("grant_wdata", bus_wdata, cur_g.wdata);
                end
            end else if (bus_req) begin
                check("busy_addr_stable", bus_addr, cur_g.addr);
                check("busy_we_stable", {31'b0, bus_we}, {31'b0, cur_g.we});
            end
            if (if_done) begin
                check("if_dm_done_overlap", {31'b0, dm_done}, 32'd0);
                if (if_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_if_done: rdata 0x%08h", if_rdata);
                end else begin
                    r = if_exp_q.pop_front();
                    check("if_rdata", if_rdata, r.rdata);
                    check("if_err", {31'b0, bus_err}, {31'b0, r.err});
                    check("if_latency", cyc - rise_cyc, r.lat);
                end
            end
            if (dm_done) begin
                if (dm_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_dm_done: rdata 0x%08h", dm_rdata);
                end else begin
                    r = dm_exp_q.pop_front();
                    check("dm_rdata", dm_rdata, r.rdata);
                    check("dm_err", {31'b0, bus_err}, {31'b0, r.err});
                    check("dm_latency", cyc - rise_cyc, r.lat);
                end
            end
            check("stall_if", {31'b0, stall_if}, {31'b0, (if_req && !if_done)});
            check("stall_mem", {31'b0, stall_mem}, {31'b0, (dm_req && !dm_done)});
            prev_req = bus_req;
        end
    end

    // ---------------- requesters ----------------
    // Both tasks are called at a falling edge and return at the falling edge
    // where their done pulse was seen, with req already dropped.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_rdata,
                            input logic exp_err, input int exp_lat, output int waited);
        resp_t r;
        r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat;
        if_exp_q.push_back(r);
        if_req  = 1'b1;
        if_addr = addr;
        waited  = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (if_done) break;
            if (waited >= 200) begin
                checks++; errors++;
                $display("FAIL fetch_wait: no if_done for addr 0x%08h after %0d cycles", addr, waited);
                break;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] dtype, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_lat, output int waited);
        resp_t r;
        r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat;
        dm_exp_q.push_back(r);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = addr;
        dm_wdata = wdata;
        dm_type  = dtype;
        waited   = 0;
        forever begin
            @(negedge clk);
            waited++;
            if (dm_done) break;
            if (waited >= 200) begin
                checks++; errors++;
                $display("FAIL data_wait: no dm_done for addr 0x%08h after %0d cycles", addr, waited);
                break;
            end
        end
        dm_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"},    {31'b0, bus_req}, 32'd0);
        check({tag, "_bus_we"},     {31'b0, bus_we}, 32'd0);
        check({tag, "_bus_addr"},   bus_addr, 32'd0);
        check({tag, "_bus_wdata"},  bus_wdata, 32'd0);
        check({tag, "_bus_dmtype"}, {29'b0, bus_dmtype}, 32'd0);
        check({tag, "_if_rdata"},   if_rdata, 32'd0);
        check({tag, "_dm_rdata"},   dm_rdata, 32'd0);
        check({tag, "_if_done"},    {31'b0, if_done}, 32'd0);
        check({tag, "_dm_done"},    {31'b0, dm_done}, 32'd0);
        check({tag, "_bus_err"},    {31'b0, bus_err}, 32'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int w, w1, w2;
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_type  = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single fetch, memory ready in the second bus cycle.
        mem_wait  = 1;
        mem_rdata = 32'h0000_0513;
        exp_grant(1'b0, 32'h0000_0010, 32'h0, 3'b010);
        do_fetch(32'h0000_0010, 32'h0000_0513, 1'b0, 2, w);
        check("t1_req_to_done", w, 32'd3);
        @(negedge clk);

        // Contention: data store wins, fetch follows after RESP.
        mem_wait  = 0;
        mem_rdata = 32'h1111_2222;
        exp_grant(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010);
        exp_grant(1'b0, 32'h0000_0014, 32'h0, 3'b010);
        fork
            do_data(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 32'h1111_2222, 1'b0, 1, w1);
            do_fetch(32'h0000_0014, 32'h1111_2222, 1'b0, 1, w2);
        join
        check("t2_store_wait", w1, 32'd2);
        check("t2_fetch_wait", w2, 32'd5);
        @(negedge clk);

        // Starvation guard: D,D,D,D,F,D,D.
        mem_wait  = 0;
        mem_rdata = 32'h3333_0000;
        for (int i = 0; i < 4; i++) exp_grant(1'b0, 32'h0000_0200 + 32'(4 * i), 32'h0, 3'b000);
        exp_grant(1'b0, 32'h0000_0040, 32'h0, 3'b010);
        for (int i = 4; i < 6; i++) exp_grant(1'b0, 32'h0000_0200 + 32'(4 * i), 32'h0, 3'b000);
        fork
            do_fetch(32'h0000_0040, 32'h3333_0000, 1'b0, 1, w2);
            begin
                for (int i = 0; i < 6; i++)
                    do_data(1'b0, 32'h0000_0200 + 32'(4 * i), 32'h5555_0000 + 32'(i), 3'b000,
                            32'h3333_0000, 1'b0, 1, w1);
            end
        join
        @(negedge clk);

        // bus_ready on the last cycle before timeout: ready wins, no error.
        mem_wait  = 7;
        mem_rdata = 32'h0000_1234;
        exp_grant(1'b0, 32'h0000_0300, 32'h0, 3'b010);
        do_data(1'b0, 32'h0000_0300, 32'h0, 3'b010, 32'h0000_1234, 1'b0, 8, w);
        check("t5_err_clear", {31'b0, bus_err}, 32'd0);
        @(negedge clk);

        // Timeout: never ready -> done 9 cycles after the grant edge, sticky error.
        mem_wait = -1;
        exp_grant(1'b0, 32'h0000_0304, 32'h0, 3'b010);
        do_data(1'b0, 32'h0000_0304, 32'h0, 3'b010, 32'h0, 1'b1, 8, w);
        check("t4_timeout_wait", w, 32'd9);
        @(negedge clk);
        check("t4_err_sticky", {31'b0, bus_err}, 32'd1);

        // Next request after timeout completes normally; error remains set.
        mem_wait  = 0;
        mem_rdata = 32'hCAFE_F00D;
        exp_grant(1'b0, 32'h0000_0308, 32'h0, 3'b010);
        do_data(1'b0, 32'h0000_0308, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b1, 1, w);
        check("t4_next_wait", w, 32'd2);
        check("t4_if_rdata_hold", if_rdata, 32'h3333_0000);
        @(negedge clk);

        // Reset in the middle of a pending load.
        mem_wait = -1;
        exp_grant(1'b0, 32'h0000_0400, 32'h0, 3'b010);
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0400;
        dm_type = 3'b010;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("t6_async");
        dm_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_wait  = 0;
        mem_rdata = 32'h0000_0077;
        exp_grant(1'b0, 32'h0000_0500, 32'h0, 3'b010);
        do_data(1'b0, 32'h0000_0500, 32'h0, 3'b010, 32'h0000_0077, 1'b0, 1, w);
        check("t6_fresh_wait", w, 32'd2);
        repeat (3) @(negedge clk);

        check("grant_queue_drained", grant_q.size(), 32'd0);
        check("if_queue_drained", if_exp_q.size(), 32'd0);
        check("dm_queue_drained", dm_exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
